// File: rtl/nios_system_sysid_arbiter_pkg.sv
// Shared types for the system-ID slave arbiter and other shared-slave arbiters.
package nios_system_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef logic master_idx_t;

endpackage

// File: rtl/nios_system_sysid_arbiter_if.sv
// Avalon-MM pipelined-read bundle, used both for master ports and the shared slave.
interface nios_system_sysid_arbiter_if #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 32
);
  // Handshake: a master holds read/address until a cycle with waitrequest=0,
  // which accepts the transfer; readdata is meaningful only while readdatavalid=1.
  logic              read;
  logic [ADDR_W-1:0] address;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master  (output read, address, input  waitrequest, readdata, readdatavalid);
  modport slave   (input  read, address, output waitrequest, readdata, readdatavalid);
  // Zero-wait-state register slave: no stall, data combinational from address.
  modport sys_host(output read, address, input  readdata);
  modport sys_dev (input  read, address, output readdata);

endinterface

// File: rtl/nios_system_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the master that did not win last time wins.
module nios_system_rr_pick
  import nios_system_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  master_idx_t            last,
  output logic                   gnt_valid,
  output master_idx_t            gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/nios_system_sysid_arbiter.sv
// Shares the system-ID register slave between two Avalon-MM read masters,
// one read per ISSUE/RESP pair, with saturating per-master grant counters.
module nios_system_sysid_arbiter
  import nios_system_arb_pkg::*;
#(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  nios_system_sysid_arbiter_if.slave    m0,
  nios_system_sysid_arbiter_if.slave    m1,
  nios_system_sysid_arbiter_if.sys_host sh,
  output logic [CNT_W-1:0]              m0_grants,
  output logic [CNT_W-1:0]              m1_grants,
  output arb_state_e                    state_dbg
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e        state_q, state_d;
  master_idx_t       grant_q, last_q, pick_idx;
  logic              pick_valid;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;
  logic              latch;

  nios_system_rr_pick u_pick (
    .req       ({m1.read, m0.read}),
    .last      (last_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // Arbitration happens in every cycle that is not an acceptance cycle.
  assign latch = (state_q != ISSUE) && pick_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_valid ? ISSUE : IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = pick_valid ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        grant_q <= pick_idx;
        addr_q  <= pick_idx ? m1.address : m0.address;
      end
      if (state_q == ISSUE) begin
        data_q <= sh.readdata;
        last_q <= grant_q;
        if (grant_q == 1'b0 && cnt0_q != '1) cnt0_q <= cnt0_q + CNT_ONE;
        if (grant_q == 1'b1 && cnt1_q != '1) cnt1_q <= cnt1_q + CNT_ONE;
      end
    end
  end

  assign sh.read    = (state_q == ISSUE);
  assign sh.address = addr_q;

  // Held high throughout reset so a transfer caught by reset is never seen as accepted.
  assign m0.waitrequest   = reset || !((state_q == ISSUE) && (grant_q == 1'b0));
  assign m1.waitrequest   = reset || !((state_q == ISSUE) && (grant_q == 1'b1));
  assign m0.readdatavalid = (state_q == RESP) && (grant_q == 1'b0);
  assign m1.readdatavalid = (state_q == RESP) && (grant_q == 1'b1);
  assign m0.readdata      = data_q;
  assign m1.readdata      = data_q;

  assign m0_grants = cnt0_q;
  assign m1_grants = cnt1_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_nios_system_sysid_arbiter.sv
// Bench for the system-ID arbiter: directed vector table, corner sequences,
// and random traffic against a transaction-slot reference model.
module tb_nios_system_sysid_arbiter;
  import nios_system_arb_pkg::*;

  localparam logic [31:0] SYSID = 32'h6266B355;

  typedef struct {
    bit rst; bit r0; bit a0; bit r1; bit a1;
    bit w0; bit w1; bit sr; bit v0; bit v1; bit sa;
    logic [31:0] rd; int g0; int g1;
  } vec_t;

  // ---------------- clock / reset / stimulus ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  bit rst = 1'b1;
  bit r0, a0, r1, a1;

  nios_system_sysid_arbiter_if #(.ADDR_W(1), .DATA_W(32)) m0_if (), m1_if (), sh_if ();
  nios_system_sysid_arbiter_if #(.ADDR_W(1), .DATA_W(32)) sm0_if (), sm1_if (), ssh_if ();

  assign m0_if.read  = r0;  assign m0_if.address  = a0;
  assign m1_if.read  = r1;  assign m1_if.address  = a1;
  assign sm0_if.read = r0;  assign sm0_if.address = a0;
  assign sm1_if.read = r1;  assign sm1_if.address = a1;
  assign sh_if.readdata  = sh_if.address[0]  ? SYSID : 32'h0;
  assign ssh_if.readdata = ssh_if.address[0] ? SYSID : 32'h0;
  assign sh_if.waitrequest  = 1'b0; assign sh_if.readdatavalid  = 1'b0;
  assign ssh_if.waitrequest = 1'b0; assign ssh_if.readdatavalid = 1'b0;

  logic [15:0] m0_grants, m1_grants;
  logic [2:0]  s_g0, s_g1;
  arb_state_e  st_dbg, s_st_dbg;

  nios_system_sysid_arbiter #(.ADDR_W(1), .DATA_W(32), .CNT_W(16)) dut (
    .clock(clock), .reset(rst), .m0(m0_if), .m1(m1_if), .sh(sh_if),
    .m0_grants(m0_grants), .m1_grants(m1_grants), .state_dbg(st_dbg)
  );

  nios_system_sysid_arbiter #(.ADDR_W(1), .DATA_W(32), .CNT_W(3)) dut_small (
    .clock(clock), .reset(rst), .m0(sm0_if), .m1(sm1_if), .sh(ssh_if),
    .m0_grants(s_g0), .m1_grants(s_g1), .state_dbg(s_st_dbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [0:0] exp_q[$];
  bit mon_on = 0;
  int last_valid_cyc = -1;
  int n_valid = 0;

  // Reference model: a slot either carries an acceptance, a response, or nothing.
  bit          m_acc, m_resp, m_acc_who, m_resp_who, m_last, m_saddr;
  logic [31:0] m_data;
  int          m_cnt[2];

  function automatic logic [31:0] sys_value(input bit a);
    return a ? SYSID : 32'h0;
  endfunction

  function automatic int sat7(input int c);
    return (c > 7) ? 7 : c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    logic [0:0] e;
    if (rst) begin
      chk("rst_wait0", 32'(m0_if.waitrequest), 1);
      chk("rst_wait1", 32'(m1_if.waitrequest), 1);
    end else begin
      chk("s_read",    32'(sh_if.read),    32'(m_acc));
      chk("s_address", 32'(sh_if.address), 32'(m_saddr));
      chk("wait0",  32'(m0_if.waitrequest),   32'(!(m_acc && m_acc_who == 1'b0)));
      chk("wait1",  32'(m1_if.waitrequest),   32'(!(m_acc && m_acc_who == 1'b1)));
      chk("valid0", 32'(m0_if.readdatavalid), 32'(m_resp && m_resp_who == 1'b0));
      chk("valid1", 32'(m1_if.readdatavalid), 32'(m_resp && m_resp_who == 1'b1));
      chk("rdata0", m0_if.readdata, m_data);
      chk("rdata1", m1_if.readdata, m_data);
      chk("grants0", 32'(m0_grants), 32'(m_cnt[0]));
      chk("grants1", 32'(m1_grants), 32'(m_cnt[1]));
      chk("sat_grants0", 32'(s_g0), 32'(sat7(m_cnt[0])));
      chk("sat_grants1", 32'(s_g1), 32'(sat7(m_cnt[1])));
      if (mon_on) begin
        if (!m0_if.waitrequest || !m1_if.waitrequest) begin
          if (exp_q.size() == 0) begin
            chk("order_extra", 32'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            chk("order", 32'(!m1_if.waitrequest), 32'(e));
          end
        end
        if (m0_if.readdatavalid || m1_if.readdatavalid) begin
          if (last_valid_cyc >= 0) chk("valid_gap", 32'(cyc - last_valid_cyc), 2);
          last_valid_cyc = cyc;
          n_valid++;
        end
      end
    end
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    chk($sformatf("tv%0d_wait0", idx), 32'(m0_if.waitrequest), 32'(v.w0));
    chk($sformatf("tv%0d_wait1", idx), 32'(m1_if.waitrequest), 32'(v.w1));
    if (!v.rst) begin
      chk($sformatf("tv%0d_s_read", idx),  32'(sh_if.read),          32'(v.sr));
      chk($sformatf("tv%0d_valid0", idx),  32'(m0_if.readdatavalid), 32'(v.v0));
      chk($sformatf("tv%0d_valid1", idx),  32'(m1_if.readdatavalid), 32'(v.v1));
      chk($sformatf("tv%0d_s_addr", idx),  32'(sh_if.address),       32'(v.sa));
      chk($sformatf("tv%0d_rdata", idx),   m0_if.readdata,           v.rd);
      chk($sformatf("tv%0d_grants0", idx), 32'(m0_grants),           32'(v.g0));
      chk($sformatf("tv%0d_grants1", idx), 32'(m1_grants),           32'(v.g1));
    end
  endtask

  task automatic update_model();
    bit was_acc, w;
    was_acc = m_acc;
    if (rst) begin
      m_acc = 0; m_resp = 0; m_last = 1; m_saddr = 0; m_data = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      if (was_acc) begin
        m_data     = sys_value(m_saddr);
        m_last     = m_acc_who;
        m_resp_who = m_acc_who;
        if (m_cnt[m_acc_who] < 65535) m_cnt[m_acc_who]++;
      end
      m_resp = was_acc;
      m_acc  = 0;
      if (!was_acc && (r0 || r1)) begin
        w = (r0 && r1) ? !m_last : r1;
        m_acc_who = w;
        m_saddr   = w ? a1 : a0;
        m_acc     = 1;
      end
    end
  endtask

  vec_t none;

  // ---------------- driver ----------------
  task automatic step(input bit use_v, input vec_t v, input int idx);
    @(negedge clock);
    check_model();
    if (use_v) check_vec(v, idx);
    @(posedge clock);
    update_model();
    cyc++;
    #1;
  endtask

  task automatic idle_step();
    step(0, none, 0);
  endtask

  task automatic set_in(input bit rr, input bit q0, input bit b0, input bit q1, input bit b1);
    rst = rr; r0 = q0; a0 = b0; r1 = q1; a1 = b1;
  endtask

  vec_t tbl[11];
  logic sa_before;

  initial begin
    none = '{0,0,0,0,0, 0,0,0,0,0,0, 32'h0, 0,0};
    tbl[0]  = '{0,1,1,0,0, 1,1,0,0,0,0, 32'h0, 0,0};
    tbl[1]  = '{0,1,1,0,0, 0,1,1,0,0,1, 32'h0, 0,0};
    tbl[2]  = '{0,0,0,0,0, 1,1,0,1,0,1, SYSID, 1,0};
    tbl[3]  = '{0,0,0,0,0, 1,1,0,0,0,1, SYSID, 1,0};
    tbl[4]  = '{1,0,0,0,0, 1,1,0,0,0,0, 32'h0, 0,0};
    tbl[5]  = '{0,1,1,1,0, 1,1,0,0,0,0, 32'h0, 0,0};
    tbl[6]  = '{0,1,1,1,0, 0,1,1,0,0,1, 32'h0, 0,0};
    tbl[7]  = '{0,0,0,1,0, 1,1,0,1,0,1, SYSID, 1,0};
    tbl[8]  = '{0,0,0,1,0, 1,0,1,0,0,0, SYSID, 1,0};
    tbl[9]  = '{0,0,0,0,0, 1,1,0,0,1,0, 32'h0, 1,1};
    tbl[10] = '{0,0,0,0,0, 1,1,0,0,0,0, 32'h0, 1,1};

    set_in(1, 0, 0, 0, 0);
    repeat (3) idle_step();

    // Directed table: single read, then simultaneous reads straight after reset.
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].rst, tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1);
      step(1, tbl[i], i);
    end

    // Continuous contention: strict alternation starting with m0.
    set_in(1, 0, 0, 0, 0); idle_step();
    for (int i = 0; i < 20; i++) exp_q.push_back(1'(i % 2));
    mon_on = 1; last_valid_cyc = -1; n_valid = 0;
    set_in(0, 1, 1, 1, 0);
    repeat (41) idle_step();
    mon_on = 0;
    chk("cont_grants0", 32'(m0_grants), 10);
    chk("cont_grants1", 32'(m1_grants), 10);
    chk("cont_valids", 32'(n_valid), 20);
    chk("cont_order_left", 32'(exp_q.size()), 0);
    set_in(0, 0, 0, 0, 0);
    repeat (3) idle_step();

    // Reset in the ISSUE cycle of an m1 read.
    set_in(1, 0, 0, 0, 0); idle_step();
    set_in(0, 0, 0, 1, 1); idle_step();
    set_in(1, 0, 0, 1, 1); idle_step();
    set_in(0, 0, 0, 0, 0); idle_step();
    chk("rst_issue_grants1", 32'(m1_grants), 0);
    set_in(0, 1, 0, 1, 1); idle_step(); idle_step();
    chk("rst_last_m0_first", 32'(m0_grants), 1);
    chk("rst_last_m1_none", 32'(m1_grants), 0);
    set_in(0, 0, 0, 0, 0);
    repeat (4) idle_step();

    // Saturation on the 3-bit-counter instance: 9 back-to-back m0 reads.
    set_in(1, 0, 0, 0, 0); idle_step();
    set_in(0, 1, 1, 0, 0);
    repeat (18) idle_step();
    chk("sat_small_g0", 32'(s_g0), 7);
    chk("sat_big_g0", 32'(m0_grants), 9);
    set_in(0, 0, 0, 0, 0);
    repeat (2) idle_step();

    // Idle: nothing moves for 20 cycles.
    sa_before = sh_if.address;
    repeat (20) idle_step();
    chk("idle_s_addr", 32'(sh_if.address), 32'(sa_before));
    chk("idle_s_read", 32'(sh_if.read), 0);

    // Random traffic, including protocol violations and occasional resets.
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle_step();
    end
    set_in(0, 0, 0, 0, 0);
    repeat (3) idle_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
